// File: rtl/msp430_pkg.sv
// ============================================================================
// Module   : msp430_pkg
// Purpose  : Shared MSP430 encoding constants, encoder state type and the
//            instruction-word packing helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package msp430_pkg;

  // Instruction format codes
  localparam logic [1:0] FMT_I   = 2'b00;
  localparam logic [1:0] FMT_II  = 2'b01;
  localparam logic [1:0] FMT_JMP = 2'b10;

  // Fixed opcode prefixes for single-operand and jump formats
  localparam logic [5:0] FMT_II_PREFIX = 6'b000100;
  localparam logic [2:0] JMP_PREFIX    = 3'b001;

  // Encoder state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_SRCX  = 2'd2,
    ST_DSTX  = 2'd3
  } enc_state_t;

  // Packs the instruction word for a (legal) request
  function automatic logic [15:0] build_iw(
    input logic [1:0] fmt,
    input logic [3:0] op,
    input logic       bw,
    input logic [1:0] as_mode,
    input logic       ad_mode,
    input logic [3:0] sa,
    input logic [3:0] da,
    input logic [9:0] off
  );
    logic [15:0] w;
    case (fmt)
      FMT_I:   w = {op, sa, ad_mode, bw, as_mode, da};
      FMT_II:  w = {FMT_II_PREFIX, op[2:0], bw, as_mode, sa};
      FMT_JMP: w = {JMP_PREFIX, op[2:0], off};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_enc_ext.sv
// ============================================================================
// Module   : instr_enc_ext
// Purpose  : Combinational legality check and source/destination
//            extension-word need flags for one request.
// Config   : INSTR_ENC_CG_EN - constant-generator encodings (R3 with As=01)
//            emit no source extension word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_enc_ext
  import msp430_pkg::*;
(
  input  logic [1:0] i_format,
  input  logic [3:0] i_opcode,
  input  logic [1:0] i_as,
  input  logic       i_ad,
  input  logic [3:0] i_sa,
  output logic       o_legal,
  output logic       o_src_ext,
  output logic       o_dst_ext
);

  logic w_src_mode_ext;

  // Source addressing modes that carry an extension word
`ifdef INSTR_ENC_CG_EN
  // R3/As=01 is constant #1; R2/R3 with As=10/11 never needed one anyway
  assign w_src_mode_ext = ((i_as == 2'b01) && (i_sa != 4'd3)) ||
                          ((i_as == 2'b11) && (i_sa == 4'd0));
`else
  assign w_src_mode_ext = (i_as == 2'b01) ||
                          ((i_as == 2'b11) && (i_sa == 4'd0));
`endif

  // Legality and per-format extension needs
  always_comb begin
    o_legal   = 1'b0;
    o_src_ext = 1'b0;
    o_dst_ext = 1'b0;
    case (i_format)
      FMT_I: begin
        o_legal   = (i_opcode >= 4'd4);
        o_src_ext = w_src_mode_ext;
        o_dst_ext = i_ad;
      end
      FMT_II: begin
        o_legal   = !i_opcode[3] && (i_opcode[2:0] != 3'd7);
        o_src_ext = w_src_mode_ext;
      end
      FMT_JMP: begin
        o_legal   = !i_opcode[3];
      end
      default: begin
        o_legal   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_enc.sv
// ============================================================================
// Module   : instr_enc
// Purpose  : MSP430 instruction encoder. Accepts one decoded request per
//            handshake and streams the instruction word plus up to two
//            extension words with valid/ready flow control.
// Config   : INSTR_ENC_CG_EN (evaluated in instr_enc_ext).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_enc
  import msp430_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  FORMAT,
  input  logic [3:0]  req_opcode,
  input  logic        req_bw,
  input  logic [1:0]  req_as,
  input  logic        req_ad,
  input  logic [3:0]  reg_SA,
  input  logic [3:0]  reg_DA,
  input  logic [15:0] req_src_ext,
  input  logic [15:0] req_dst_ext,
  input  logic [9:0]  req_jmp_off,
  output logic [15:0] MDB_out,
  output logic        MDB_valid,
  input  logic        MDB_ready,
  output logic        MDB_last,
  output logic        enc_err
);

  enc_state_t  r_state;
  enc_state_t  w_next_state;

  // Captured request fields
  logic [1:0]  r_fmt;
  logic [3:0]  r_op;
  logic        r_bw;
  logic [1:0]  r_as;
  logic        r_ad;
  logic [3:0]  r_sa;
  logic [3:0]  r_da;
  logic [15:0] r_src_ext;
  logic [15:0] r_dst_ext;
  logic [9:0]  r_off;
  logic        r_need_src;
  logic        r_need_dst;

  // Registered outputs
  logic        r_req_ready;
  logic [15:0] r_mdb_out;
  logic        r_mdb_valid;
  logic        r_mdb_last;
  logic        r_enc_err;

  // Next-value wires
  logic [15:0] w_next_out;
  logic        w_next_valid;
  logic        w_next_last;
  logic        w_next_err;
  logic        w_accept;
  logic [15:0] w_iw;

  logic        w_legal;
  logic        w_src_need;
  logic        w_dst_need;

  instr_enc_ext u_ext (
    .i_format  (FORMAT),
    .i_opcode  (req_opcode),
    .i_as      (req_as),
    .i_ad      (req_ad),
    .i_sa      (reg_SA),
    .o_legal   (w_legal),
    .o_src_ext (w_src_need),
    .o_dst_ext (w_dst_need)
  );

  assign w_iw = build_iw(r_fmt, r_op, r_bw, r_as, r_ad, r_sa, r_da, r_off);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and next output values; first word is loaded one cycle
  // after acceptance, later words are loaded on the preceding handshake
  always_comb begin
    w_next_state = r_state;
    w_next_out   = r_mdb_out;
    w_next_valid = r_mdb_valid;
    w_next_last  = r_mdb_last;
    w_next_err   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          if (w_legal) begin
            w_accept     = 1'b1;
            w_next_state = ST_INSTR;
          end else begin
            w_next_err   = 1'b1;
          end
        end
      end
      ST_INSTR: begin
        if (!r_mdb_valid) begin
          w_next_out   = w_iw;
          w_next_valid = 1'b1;
          w_next_last  = !r_need_src && !r_need_dst;
        end else if (MDB_ready) begin
          if (r_need_src) begin
            w_next_state = ST_SRCX;
            w_next_out   = r_src_ext;
            w_next_last  = !r_need_dst;
          end else if (r_need_dst) begin
            w_next_state = ST_DSTX;
            w_next_out   = r_dst_ext;
            w_next_last  = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
            w_next_out   = 16'h0000;
            w_next_valid = 1'b0;
            w_next_last  = 1'b0;
          end
        end
      end
      ST_SRCX: begin
        if (MDB_ready) begin
          if (r_need_dst) begin
            w_next_state = ST_DSTX;
            w_next_out   = r_dst_ext;
            w_next_last  = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
            w_next_out   = 16'h0000;
            w_next_valid = 1'b0;
            w_next_last  = 1'b0;
          end
        end
      end
      ST_DSTX: begin
        if (MDB_ready) begin
          w_next_state = ST_IDLE;
          w_next_out   = 16'h0000;
          w_next_valid = 1'b0;
          w_next_last  = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_mdb_out   <= 16'h0000;
      r_mdb_valid <= 1'b0;
      r_mdb_last  <= 1'b0;
      r_enc_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_next_state == ST_IDLE);
      r_mdb_out   <= w_next_out;
      r_mdb_valid <= w_next_valid;
      r_mdb_last  <= w_next_last;
      r_enc_err   <= w_next_err;
    end
  end

  // Request capture on legal acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fmt      <= 2'b00;
      r_op       <= 4'h0;
      r_bw       <= 1'b0;
      r_as       <= 2'b00;
      r_ad       <= 1'b0;
      r_sa       <= 4'h0;
      r_da       <= 4'h0;
      r_src_ext  <= 16'h0000;
      r_dst_ext  <= 16'h0000;
      r_off      <= 10'h000;
      r_need_src <= 1'b0;
      r_need_dst <= 1'b0;
    end else if (w_accept) begin
      r_fmt      <= FORMAT;
      r_op       <= req_opcode;
      r_bw       <= req_bw;
      r_as       <= req_as;
      r_ad       <= req_ad;
      r_sa       <= reg_SA;
      r_da       <= reg_DA;
      r_src_ext  <= req_src_ext;
      r_dst_ext  <= req_dst_ext;
      r_off      <= req_jmp_off;
      r_need_src <= w_src_need;
      r_need_dst <= w_dst_need;
    end
  end

  assign req_ready = r_req_ready;
  assign MDB_out   = r_mdb_out;
  assign MDB_valid = r_mdb_valid;
  assign MDB_last  = r_mdb_last;
  assign enc_err   = r_enc_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_enc.sv
// ============================================================================
// Module   : tb_instr_enc
// Purpose  : Directed self-checking bench for instr_enc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_enc;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  FORMAT;
  logic [3:0]  req_opcode;
  logic        req_bw;
  logic [1:0]  req_as;
  logic        req_ad;
  logic [3:0]  reg_SA;
  logic [3:0]  reg_DA;
  logic [15:0] req_src_ext;
  logic [15:0] req_dst_ext;
  logic [9:0]  req_jmp_off;
  logic [15:0] MDB_out;
  logic        MDB_valid;
  logic        MDB_ready;
  logic        MDB_last;
  logic        enc_err;

  int n_assert = 0;
  int n_fail   = 0;

  instr_enc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .FORMAT      (FORMAT),
    .req_opcode  (req_opcode),
    .req_bw      (req_bw),
    .req_as      (req_as),
    .req_ad      (req_ad),
    .reg_SA      (reg_SA),
    .reg_DA      (reg_DA),
    .req_src_ext (req_src_ext),
    .req_dst_ext (req_dst_ext),
    .req_jmp_off (req_jmp_off),
    .MDB_out     (MDB_out),
    .MDB_valid   (MDB_valid),
    .MDB_ready   (MDB_ready),
    .MDB_last    (MDB_last),
    .enc_err     (enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the currently presented word
  task automatic chk_word(input string tag, input logic [15:0] exp_w, input logic exp_last);
    chk({tag, " valid"}, {31'd0, MDB_valid}, 32'd1);
    chk({tag, " out"},   {16'd0, MDB_out},   {16'd0, exp_w});
    chk({tag, " last"},  {31'd0, MDB_last},  {31'd0, exp_last});
  endtask

  // Presents a request for one edge; legal requests must be accepted there
  task automatic send(input logic [1:0] fmt, input logic [3:0] op, input logic [1:0] as_m,
                      input logic ad_m, input logic [3:0] sa, input logic [3:0] da,
                      input logic [15:0] sx, input logic [15:0] dx, input logic [9:0] off);
    FORMAT = fmt; req_opcode = op; req_bw = 1'b0; req_as = as_m; req_ad = ad_m;
    reg_SA = sa; reg_DA = da; req_src_ext = sx; req_dst_ext = dx; req_jmp_off = off;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; MDB_ready = 1'b1;
    FORMAT = 2'b00; req_opcode = 4'h0; req_bw = 1'b0; req_as = 2'b00; req_ad = 1'b0;
    reg_SA = 4'h0; reg_DA = 4'h0; req_src_ext = 16'h0; req_dst_ext = 16'h0; req_jmp_off = 10'h0;

    // Reset state
    tick(); tick(); tick();
    chk("rst ready", {31'd0, req_ready}, 32'd0);
    chk("rst valid", {31'd0, MDB_valid}, 32'd0);
    chk("rst out",   {16'd0, MDB_out},   32'd0);
    chk("rst last",  {31'd0, MDB_last},  32'd0);
    chk("rst err",   {31'd0, enc_err},   32'd0);
    rst_n = 1'b1;
    tick();
    chk("post-rst ready", {31'd0, req_ready}, 32'd1);

    // MOV #0x1234,R5
    send(2'b00, 4'h4, 2'b11, 1'b0, 4'd0, 4'd5, 16'h1234, 16'h0000, 10'h000);
    chk("imm lat valid", {31'd0, MDB_valid}, 32'd0);
    chk("imm lat ready", {31'd0, req_ready}, 32'd0);
    tick(); chk_word("imm w0", 16'h4035, 1'b0);
    tick(); chk_word("imm w1", 16'h1234, 1'b1);
    tick();
    chk("imm end valid", {31'd0, MDB_valid}, 32'd0);
    chk("imm end ready", {31'd0, req_ready}, 32'd1);

    // MOV 2(R4),4(R5) with backpressure on the second word
    send(2'b00, 4'h4, 2'b01, 1'b1, 4'd4, 4'd5, 16'h0002, 16'h0004, 10'h000);
    tick(); chk_word("idx w0", 16'h4495, 1'b0);
    tick(); chk_word("idx w1", 16'h0002, 1'b0);
    MDB_ready = 1'b0;
    tick(); chk_word("idx hold1", 16'h0002, 1'b0);
    tick(); chk_word("idx hold2", 16'h0002, 1'b0);
    tick(); chk_word("idx hold3", 16'h0002, 1'b0);
    MDB_ready = 1'b1;
    tick(); chk_word("idx w2", 16'h0004, 1'b1);
    tick();
    chk("idx end valid", {31'd0, MDB_valid}, 32'd0);

    // JMP cond 7, offset 0x3FF
    send(2'b10, 4'h7, 2'b00, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 10'h3FF);
    tick(); chk_word("jmp w0", 16'h3FFF, 1'b1);
    tick();
    chk("jmp end valid", {31'd0, MDB_valid}, 32'd0);
    chk("jmp end ready", {31'd0, req_ready}, 32'd1);

    // PUSH R5
    send(2'b01, 4'h4, 2'b00, 1'b0, 4'd5, 4'd0, 16'h0000, 16'h0000, 10'h000);
    tick(); chk_word("push w0", 16'h1205, 1'b1);
    tick();

    // PUSH #0x5555 (Format II immediate takes a source extension)
    send(2'b01, 4'h4, 2'b11, 1'b0, 4'd0, 4'd0, 16'h5555, 16'h0000, 10'h000);
    tick(); chk_word("pushi w0", 16'h1230, 1'b0);
    tick(); chk_word("pushi w1", 16'h5555, 1'b1);
    tick();

    // MOV #1,R6 via R3/As=01
    send(2'b00, 4'h4, 2'b01, 1'b0, 4'd3, 4'd6, 16'hBEEF, 16'h0000, 10'h000);
`ifdef INSTR_ENC_CG_EN
    tick(); chk_word("cg w0", 16'h4316, 1'b1);
`else
    tick(); chk_word("cg w0", 16'h4316, 1'b0);
    tick(); chk_word("cg w1", 16'hBEEF, 1'b1);
`endif
    tick();
    chk("cg end valid", {31'd0, MDB_valid}, 32'd0);

    // Illegal: FORMAT = 11
    send(2'b11, 4'h4, 2'b00, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 10'h000);
    chk("ill11 err",   {31'd0, enc_err},   32'd1);
    chk("ill11 valid", {31'd0, MDB_valid}, 32'd0);
    chk("ill11 ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("ill11 err clr", {31'd0, enc_err},   32'd0);
    chk("ill11 valid2",  {31'd0, MDB_valid}, 32'd0);

    // Illegal: Format I opcode 2
    send(2'b00, 4'h2, 2'b00, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 10'h000);
    chk("ilop err",   {31'd0, enc_err},   32'd1);
    chk("ilop ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("ilop err clr", {31'd0, enc_err},   32'd0);
    chk("ilop valid",   {31'd0, MDB_valid}, 32'd0);

    // Illegal: Format II opcode 7, and Jump with opcode[3] set
    send(2'b01, 4'h7, 2'b00, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 10'h000);
    chk("ilf2 err", {31'd0, enc_err}, 32'd1);
    send(2'b10, 4'h8, 2'b00, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h0000, 10'h000);
    chk("iljmp err", {31'd0, enc_err}, 32'd1);
    tick();
    chk("iljmp valid", {31'd0, MDB_valid}, 32'd0);

    // Reset while the second of three words is pending
    send(2'b00, 4'h4, 2'b01, 1'b1, 4'd4, 4'd5, 16'h0002, 16'h0004, 10'h000);
    tick(); chk_word("rmid w0", 16'h4495, 1'b0);
    tick(); chk_word("rmid w1", 16'h0002, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rmid valid", {31'd0, MDB_valid}, 32'd0);
    chk("rmid out",   {16'd0, MDB_out},   32'd0);
    chk("rmid last",  {31'd0, MDB_last},  32'd0);
    chk("rmid ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rmid ready2", {31'd0, req_ready}, 32'd1);
    send(2'b01, 4'h4, 2'b00, 1'b0, 4'd5, 4'd0, 16'h0000, 16'h0000, 10'h000);
    tick(); chk_word("rmid push", 16'h1205, 1'b1);
    tick();
    chk("rmid end valid", {31'd0, MDB_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
